// File: rtl/mem_responder_if.sv
// Core-to-memory request/response bundle.
// master: the core (drives requests); slave: the memory responder.
interface mem_responder_if;
    logic        read;
    logic        write_mem;
    logic [31:0] mar;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        ready;
    logic        err;
    logic        busy;

    modport master (
        output read, write_mem, mar, wr_data,
        input  rd_data, ready, err, busy
    );

    modport slave (
        input  read, write_mem, mar, wr_data,
        output rd_data, ready, err, busy
    );
endinterface

// File: rtl/mem_responder.sv
// Wait-state memory responder with a four-phase ready handshake.
// Ports: clk, reset (sync, active-high), bus (slave side of mem_responder_if).
module mem_responder #(
    parameter int ADDR_BITS   = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    logic [31:0] mem [2**ADDR_BITS];

    logic [1:0]           state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 ph_q, ph_d;
    logic                 wr_q, wr_d;
    logic                 err_q, err_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [31:0]          data_q, data_d;
    logic [31:0]          rd_q, rd_d;

    logic req;
    logic hi_bad;
    logic do_acc;

    assign req    = bus.read | bus.write_mem;
    assign hi_bad = |(bus.mar >> ADDR_BITS);
    // The access itself happens on the edge that leaves the second
    // ACCESS phase; the first phase is the address-setup cycle.
    assign do_acc = (state_q == S_ACCESS) && ph_q && !err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ph_d    = ph_q;
        wr_d    = wr_q;
        err_d   = err_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rd_d    = rd_q;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d = bus.mar[ADDR_BITS-1:0];
                    data_d = bus.wr_data;
                    wr_d   = bus.write_mem;
                    err_d  = (bus.read & bus.write_mem) | hi_bad;
                    ph_d   = 1'b0;
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_ACCESS;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = S_ACCESS;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACCESS: begin
                if (!ph_q) begin
                    ph_d = 1'b1;
                end else begin
                    ph_d    = 1'b0;
                    state_d = S_DONE;
                    if (do_acc && !wr_q) begin
                        rd_d = mem[addr_q];
                    end
                end
            end
            S_DONE: begin
                if (!req) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            ph_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= 32'h0;
            rd_q    <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rd_q    <= rd_d;
        end
    end

    // Array has no reset so its contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (!reset && do_acc && wr_q) begin
            mem[addr_q] <= data_q;
        end
    end

    assign bus.rd_data = rd_q;
    assign bus.ready   = (state_q == S_DONE);
    assign bus.err     = (state_q == S_DONE) & err_q;
    assign bus.busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (WAIT_CYCLES=2 and 0 instances).
// Drives transactions through the interface and checks hand-computed values.
module tb_mem_responder;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    mem_responder_if m ();
    mem_responder_if z ();

    mem_responder #(.ADDR_BITS(9), .WAIT_CYCLES(2)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (m)
    );

    mem_responder #(.ADDR_BITS(9), .WAIT_CYCLES(0)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One full transaction on the WAIT_CYCLES=2 instance. mar switches
    // to a2 right after capture; lat counts edges from capture to ready.
    task automatic txn(input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] a2,
                       input logic [31:0] d, output int lat,
                       output logic [31:0] rdv, output logic errv);
        m.read      = r;
        m.write_mem = w;
        m.mar       = a;
        m.wr_data   = d;
        @(posedge clk);
        #1;
        m.mar     = a2;
        m.wr_data = ~d;
        lat = 0;
        while (!m.ready && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rdv = m.rd_data;
        errv = m.err;
        m.read      = 1'b0;
        m.write_mem = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_after", {30'd0, m.busy, m.ready}, 32'd0);
    endtask

    int          lat;
    logic [31:0] rdv;
    logic        errv;
    int          hold_ok;

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b1;
        m.read      = 1'b0;
        m.write_mem = 1'b0;
        m.mar       = 32'h0;
        m.wr_data   = 32'h0;
        z.read      = 1'b0;
        z.write_mem = 1'b0;
        z.mar       = 32'h0;
        z.wr_data   = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, m.ready}, 32'd0);
        chk("rst_err", {31'd0, m.err}, 32'd0);
        chk("rst_busy", {31'd0, m.busy}, 32'd0);
        chk("rst_rd", m.rd_data, 32'h0);
        reset = 1'b0;

        txn(1'b0, 1'b1, 32'd5, 32'd5, 32'hDEADBEEF, lat, rdv, errv);
        chk("wr5_lat", lat, 4);
        chk("wr5_err", {31'd0, errv}, 32'd0);
        chk("wr5_rd", rdv, 32'h0);

        txn(1'b1, 1'b0, 32'd5, 32'd5, 32'h0, lat, rdv, errv);
        chk("rd5_lat", lat, 4);
        chk("rd5_data", rdv, 32'hDEADBEEF);
        chk("rd5_err", {31'd0, errv}, 32'd0);

        txn(1'b0, 1'b1, 32'd3, 32'd3, 32'h33333333, lat, rdv, errv);
        txn(1'b0, 1'b1, 32'd0, 32'd0, 32'h00000A0A, lat, rdv, errv);
        txn(1'b0, 1'b1, 32'd7, 32'd7, 32'h00000077, lat, rdv, errv);
        txn(1'b0, 1'b1, 32'd2, 32'd2, 32'h22222222, lat, rdv, errv);
        txn(1'b0, 1'b1, 32'd9, 32'd9, 32'h99999999, lat, rdv, errv);
        chk("wr9_lat", lat, 4);

        txn(1'b1, 1'b1, 32'd3, 32'd3, 32'h00000BAD, lat, rdv, errv);
        chk("both_err", {31'd0, errv}, 32'd1);
        chk("both_rd", rdv, 32'hDEADBEEF);
        txn(1'b1, 1'b0, 32'd3, 32'd3, 32'h0, lat, rdv, errv);
        chk("rd3_data", rdv, 32'h33333333);

        txn(1'b0, 1'b1, 32'h200, 32'h200, 32'h0000BAD2, lat, rdv, errv);
        chk("hi_err", {31'd0, errv}, 32'd1);
        chk("hi_rd", rdv, 32'h33333333);
        txn(1'b1, 1'b0, 32'd0, 32'd0, 32'h0, lat, rdv, errv);
        chk("rd0_data", rdv, 32'h00000A0A);
        chk("rd0_err", {31'd0, errv}, 32'd0);

        // Reset in WAIT aborts the write; a read held across reset
        // release is captured on the first edge with reset low.
        m.write_mem = 1'b1;
        m.mar       = 32'd7;
        m.wr_data   = 32'h00001234;
        @(posedge clk);
        #1;
        chk("mid_busy", {31'd0, m.busy}, 32'd1);
        @(posedge clk);
        #1;
        reset       = 1'b1;
        m.write_mem = 1'b0;
        m.read      = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_out", {m.rd_data[29:0], m.busy, m.ready}, 32'd0);
        chk("mid_rst_err", {31'd0, m.err}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rel_capture", {31'd0, m.busy}, 32'd1);
        lat = 0;
        while (!m.ready && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("rel_lat", lat, 4);
        chk("rd7_data", m.rd_data, 32'h00000077);
        m.read = 1'b0;
        @(posedge clk);
        #1;

        txn(1'b1, 1'b0, 32'd2, 32'd9, 32'h0, lat, rdv, errv);
        chk("late_mar", rdv, 32'h22222222);

        // Held read: ready stays up, no second transaction starts.
        m.read = 1'b1;
        m.mar  = 32'd5;
        @(posedge clk);
        #1;
        lat = 0;
        while (!m.ready && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("hold_lat", lat, 4);
        hold_ok = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (m.ready && m.busy) hold_ok++;
        end
        chk("hold_ready", hold_ok, 10);
        chk("hold_rd", m.rd_data, 32'hDEADBEEF);
        m.read = 1'b0;
        @(posedge clk);
        #1;
        chk("hold_drop", {30'd0, m.busy, m.ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("hold_norecap", {31'd0, m.busy}, 32'd0);

        // Zero-wait instance: write then read back.
        z.write_mem = 1'b1;
        z.mar       = 32'd5;
        z.wr_data   = 32'hCAFE0005;
        @(posedge clk);
        #1;
        lat = 0;
        while (!z.ready && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("z_wr_lat", lat, 2);
        z.write_mem = 1'b0;
        @(posedge clk);
        #1;
        z.read = 1'b1;
        @(posedge clk);
        #1;
        lat = 0;
        while (!z.ready && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("z_rd_lat", lat, 2);
        chk("z_rd_data", z.rd_data, 32'hCAFE0005);
        z.read = 1'b0;
        @(posedge clk);
        #1;
        chk("z_idle", {30'd0, z.busy, z.ready}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
